// File: rtl/fir_inverse_3tap.sv
// Inverse of the 3-tap FIR y = x + C1*x[n-1] + C2*x[n-2]. Rebuilds the narrow
// samples from the wide FIR stream, saturating and flagging overflow.
module fir_inverse_3tap #(
  parameter int IN_W   = 20,
  parameter int OUT_W  = 8,
  parameter int COEF_W = 8,
  parameter int C1     = 2,
  parameter int C2     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  data_in,
  input  logic                    valid_in,
  input  logic                    flush,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    valid_out,
  output logic                    ovf_pulse,
  output logic                    ovf_sticky
);

  localparam int A = ((IN_W > COEF_W + OUT_W) ? IN_W : COEF_W + OUT_W) + 2;

  localparam logic signed [COEF_W-1:0] C1_K = COEF_W'(C1);
  localparam logic signed [COEF_W-1:0] C2_K = COEF_W'(C2);
  localparam logic signed [A-1:0]      C1_A = A'(C1_K);
  localparam logic signed [A-1:0]      C2_A = A'(C2_K);

  localparam logic signed [A-1:0] X_MAX = A'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [A-1:0] X_MIN = -X_MAX - A'(1);

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]              state_q, state_d;
  logic signed [OUT_W-1:0] h1_q, h1_d, h2_q, h2_d;
  logic signed [OUT_W-1:0] dout_q, dout_d;
  logic                    vout_q, vout_d;
  logic                    pulse_q, pulse_d;
  logic                    sticky_q, sticky_d;

  logic signed [OUT_W-1:0] h1_use, h2_use;
  logic signed [A-1:0]     y_x, p1, p2, acc;
  logic signed [OUT_W-1:0] x_sat;
  logic                    sat;

  // History is forced to zero while priming or flushing; in PRIME it is
  // already zero, so the gate only makes the stream-start contract explicit.
  always_comb begin
    h1_use = h1_q;
    h2_use = h2_q;
    if (flush || state_q == ST_PRIME) begin
      h1_use = '0;
      h2_use = '0;
    end
  end

  // Full-precision products; A bits hold every product and the difference.
  always_comb begin
    y_x = A'(data_in);
    p1  = C1_A * A'(h1_use);
    p2  = C2_A * A'(h2_use);
    acc = y_x - p1 - p2;
  end

  always_comb begin
    x_sat = acc[OUT_W-1:0];
    sat   = 1'b0;
    if (acc > X_MAX) begin
      x_sat = X_MAX[OUT_W-1:0];
      sat   = 1'b1;
    end else if (acc < X_MIN) begin
      x_sat = X_MIN[OUT_W-1:0];
      sat   = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    h1_d     = h1_q;
    h2_d     = h2_q;
    dout_d   = dout_q;
    sticky_d = sticky_q;
    vout_d   = valid_in;
    pulse_d  = valid_in & sat;
    if (valid_in) begin
      // Saturated value goes into history so the recursion stays bounded.
      dout_d   = x_sat;
      sticky_d = sticky_q | sat;
      h2_d     = h1_use;
      h1_d     = x_sat;
      state_d  = ST_RUN;
    end else if (flush) begin
      h1_d    = '0;
      h2_d    = '0;
      state_d = ST_PRIME;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PRIME;
      h1_q     <= '0;
      h2_q     <= '0;
      dout_q   <= '0;
      vout_q   <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      h1_q     <= h1_d;
      h2_q     <= h2_d;
      dout_q   <= dout_d;
      vout_q   <= vout_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign data_out   = dout_q;
  assign valid_out  = vout_q;
  assign ovf_pulse  = pulse_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fir_inverse_3tap.sv
// Scoreboard bench for fir_inverse_3tap: directed vectors push expected
// results, a negedge monitor pops and compares on every valid_out.
module tb_fir_inverse_3tap;

  localparam int IN_W  = 20;
  localparam int OUT_W = 8;

  typedef struct {
    logic signed [OUT_W-1:0] d;
    logic                    p;
    logic                    s;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [IN_W-1:0]  data_in;
  logic                    valid_in;
  logic                    flush;
  logic signed [OUT_W-1:0] data_out;
  logic                    valid_out;
  logic                    ovf_pulse;
  logic                    ovf_sticky;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  fir_inverse_3tap #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(8), .C1(2), .C2(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .flush(flush),
    .data_out(data_out), .valid_out(valid_out), .ovf_pulse(ovf_pulse),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  // Monitor: every presented output must match the oldest expectation.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got data_out=%0d with empty scoreboard", data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data_out !== e.d || ovf_pulse !== e.p || ovf_sticky !== e.s) begin
          errors++;
          $display("FAIL out_sample: got d=%0d p=%b s=%b, expected d=%0d p=%b s=%b",
                   data_out, ovf_pulse, ovf_sticky, e.d, e.p, e.s);
        end
      end
    end
  end

  task automatic send(input int y, input bit fl, input int ex, input bit ep, input bit es);
    exp_t e;
    @(negedge clk);
    rst      = 1'b0;
    data_in  = IN_W'(y);
    valid_in = 1'b1;
    flush    = fl;
    e.d = OUT_W'(ex);
    e.p = ep;
    e.s = es;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit fl);
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
    flush    = fl;
  endtask

  task automatic chk_idle(input string name, input int ed, input bit es);
    checks++;
    if (valid_out !== 1'b0 || ovf_pulse !== 1'b0 || data_out !== OUT_W'(ed) || ovf_sticky !== es) begin
      errors++;
      $display("FAIL %s: got v=%b d=%0d p=%b s=%b, expected v=0 d=%0d p=0 s=%b",
               name, valid_out, data_out, ovf_pulse, ovf_sticky, ed, es);
    end
  endtask

  initial begin
    rst = 1'b1; data_in = '0; valid_in = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset_state", 0, 1'b0);

    // Impulse
    send(10, 0, 10, 0, 0);
    send(20, 0, 0, 0, 0);
    send(10, 0, 0, 0, 0);
    send(0,  0, 0, 0, 0);
    idle(1);

    // Extremes without saturation
    send(-128, 0, -128, 0, 0);
    send(-129, 0, 127, 0, 0);
    send(126,  0, 0, 0, 0);
    idle(1);

    // Gapped valid: data_out holds 10 during the gap
    send(10, 0, 10, 0, 0);
    idle(0);
    @(negedge clk); chk_idle("gap_hold1", 10, 1'b0);
    @(negedge clk); chk_idle("gap_hold2", 10, 1'b0);
    chk_idle("gap_hold3", 10, 1'b0);
    send(20, 0, 0, 0, 0);
    send(10, 0, 0, 0, 0);
    idle(1);

    // Flush with a same-cycle sample uses zero history
    send(10, 0, 10, 0, 0);
    send(5,  1, 5, 0, 0);
    idle(1);

    // Overflow both directions
    send(200,  0, 127, 1, 1);
    send(-300, 0, -128, 1, 1);
    idle(1);
    @(negedge clk); chk_idle("ovf_sticky_hold", -128, 1'b1);
    idle(0);

    // Reset mid-stream clears everything including sticky
    send(10, 0, 10, 0, 1);
    send(20, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk_idle("midstream_reset", 0, 1'b0);
    send(7, 0, 7, 0, 0);
    idle(0);

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never appeared, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
